// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding, ACK/NACK bus
// levels and R/W bit meaning.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WR_DATA   = 3'd3,
        ST_WR_ACK    = 3'd4,
        ST_RD_DATA   = 3'd5,
        ST_RD_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes the raw SCL/SDA bus levels into the clk domain and derives
// single-cycle event strobes from the synchronized levels only.
//   clk, areset_n  : system clock, asynchronous active-low reset
//   scl_in, sda_in : raw bus levels
//   sda_o          : synchronized SDA level
//   scl_rise_o     : 1-cycle strobe, synchronized SCL went 0->1
//   scl_fall_o     : 1-cycle strobe, synchronized SCL went 1->0
//   start_o        : 1-cycle strobe, SDA fell while SCL stayed high
//   stop_o         : 1-cycle strobe, SDA rose while SCL stayed high
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2  // must be >= 2
) (
    input  logic clk,
    input  logic areset_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    // Preset to 1 so an idle (pulled-up) bus produces no edges out of reset.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    assign sda_o      = sda_s;
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    // SCL must be high on both sides of the SDA edge, so an SDA change that
    // races an SCL edge is treated as data rather than a bus condition.
    assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave_target.sv
// I2C target (slave) on the translator's slave-side bus. Answers to a fixed
// 7-bit address, ACKs it, receives write bytes or returns read bytes.
//   clk, areset_n : system clock (>= 8x SCL), asynchronous active-low reset
//   scl_in        : bus SCL level (never stretched)
//   sda_in        : bus SDA level
//   sda_oe        : 1 = pull SDA low, 0 = release (open drain)
//   tx_data       : next read byte, sampled when tx_req pulses
//   tx_req        : 1-cycle pulse, tx_data loaded into the shifter
//   rx_data       : last byte written by the master
//   rx_valid      : 1-cycle pulse when rx_data updates
//   addr_hit      : 1-cycle pulse on address match
//   rw            : R/W bit of the current transfer (1 = read)
//   busy          : high from address match until STOP
//   dbg_state_o   : current FSM state
module i2c_slave_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h7F,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       areset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_hit,
    output logic       rw,
    output logic       busy,
    output logic [2:0] dbg_state_o
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .areset_n   (areset_n),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    // Only 7 bits are stored: on receive the 8th bit comes straight from SDA,
    // on transmit the MSB is driven directly from tx_data at load time.
    logic [6:0] shift_q, shift_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       addr_hit_q, addr_hit_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;
    logic [7:0] rx_byte;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 7'd0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            addr_hit_q <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            addr_hit_q <= addr_hit_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        addr_hit_d = 1'b0;
        rw_d       = rw_q;
        busy_d     = busy_q;
        rx_byte    = {shift_q, sda_s};

        if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (start_det) begin
            // busy is kept across a repeated START so the combined transfer
            // looks continuous; the next address byte decides whether it stays.
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_byte[7:1] == SLAVE_ADDR) begin
                                rw_d       = rx_byte[0];
                                addr_hit_d = 1'b1;
                                busy_d     = 1'b1;
                                state_d    = ST_ADDR_ACK;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = ST_WAIT_STOP;
                            end
                        end
                    end
                end
                // In both ACK states sda_oe is still 0 on entry, so it marks
                // whether the first (ACK-start) SCL fall has already happened.
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else if (rw_q == RW_WRITE) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_WR_DATA;
                        end else begin
                            shift_d  = tx_data[6:0];
                            tx_req_d = 1'b1;
                            sda_oe_d = ~tx_data[7];
                            state_d  = ST_RD_DATA;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = rx_byte;
                            rx_valid_d = 1'b1;
                            state_d    = ST_WR_ACK;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_WR_DATA;
                        end
                    end
                end
                // bit_cnt counts bits the master has clocked; it is back at 0
                // only after the 8th rise, so that fall ends the byte.
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q != 3'd0) begin
                            sda_oe_d = ~shift_q[6];
                            shift_d  = {shift_q[5:0], 1'b0};
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RD_ACK;
                        end
                    end
                end
                // bit_cnt=1 records that the master ACKed on this clock.
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == I2C_NACK) begin
                            state_d = ST_WAIT_STOP;
                        end else begin
                            bit_cnt_d = 3'd1;
                        end
                    end else if (scl_fall && bit_cnt_q == 3'd1) begin
                        bit_cnt_d = 3'd0;
                        shift_d   = tx_data[6:0];
                        tx_req_d  = 1'b1;
                        sda_oe_d  = ~tx_data[7];
                        state_d   = ST_RD_DATA;
                    end
                end
                ST_WAIT_STOP: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign sda_oe      = sda_oe_q;
    assign tx_req      = tx_req_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign addr_hit    = addr_hit_q;
    assign rw          = rw_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bench for i2c_slave_target: a behavioural I2C master drives the open-drain
// bus; expected ACKs, read bytes, pulse counts and received bytes come from
// the transaction description (address, direction, data) alone.
module tb_i2c_slave_target;
    import i2c_pkg::*;

    localparam logic [6:0] SLAVE_ADDR = 7'h7F;
    localparam int         Q          = 8;  // clk cycles per quarter SCL period

    // ---------------- clock / reset / DUT ----------------
    logic       clk;
    logic       areset_n;
    logic       scl_m;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] tx_data;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_hit;
    logic       rw;
    logic       busy;
    logic [2:0] dbg_state_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wired-AND open-drain bus: master releases with 1, target pulls low.
    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_target #(.SLAVE_ADDR(SLAVE_ADDR), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .areset_n    (areset_n),
        .scl_in      (scl_m),
        .sda_in      (sda_bus),
        .sda_oe      (sda_oe),
        .tx_data     (tx_data),
        .tx_req      (tx_req),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .addr_hit    (addr_hit),
        .rw          (rw),
        .busy        (busy),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- scoreboard state ----------------
    int         n_vec = 0;
    int         n_err = 0;
    int         hit_cnt, rxv_cnt, txr_cnt, overlap;
    logic       oe_seen;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] txd[4];
    logic       exp_busy;
    logic       last_rw;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor samples away from the active edge.
    always @(negedge clk) begin
        if (addr_hit) hit_cnt++;
        if (tx_req) txr_cnt++;
        if (rx_valid) begin
            rxv_cnt++;
            got_q.push_back(rx_data);
        end
        if (rx_valid && tx_req) overlap++;
        if (sda_oe) oe_seen = 1'b1;
    end

    // ---------------- master driver tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Works from idle (SCL high) and as a repeated START (SCL low).
    task automatic bus_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    // glitch: toggle SDA a few times while SCL is low before settling.
    task automatic send_bit(input logic b, input logic glitch);
        if (glitch) begin
            sda_m = ~b; wait_clk(2);
            sda_m = b;  wait_clk(2);
            sda_m = ~b; wait_clk(1);
        end
        sda_m = b;    wait_clk(Q);
        scl_m = 1'b1; wait_clk(2 * Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        @(negedge clk) b = sda_bus;
        wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic glitch);
        for (int i = 7; i >= 0; i--) send_bit(d[i], glitch);
    endtask

    task automatic recv_byte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
    endtask

    // One addressed transfer of n bytes taken from txd[]; expectations follow
    // from whether the address matches and from the direction bit.
    task automatic run_txn(input logic [6:0] addr, input logic rwb, input int n,
                           input logic glitch, input logic do_stop);
        logic       match;
        logic       b;
        logic [7:0] got;
        logic [7:0] exp_b;
        match   = (addr == SLAVE_ADDR);
        hit_cnt = 0; rxv_cnt = 0; txr_cnt = 0; overlap = 0; oe_seen = 1'b0;
        got_q.delete();
        bus_start();
        check_val("busy_at_start", {31'd0, busy}, {31'd0, exp_busy});
        send_byte({addr, rwb}, 1'b0);
        if (rwb == RW_READ) tx_data = txd[0];
        recv_bit(b);
        check_val("addr_ack", {31'd0, b}, {31'd0, match ? I2C_ACK : I2C_NACK});
        check_val("busy_after_addr", {31'd0, busy}, {31'd0, match});
        exp_busy = match;
        if (match) last_rw = rwb;
        if (match && rwb == RW_READ) begin
            for (int i = 0; i < n; i++) begin
                recv_byte(got);
                check_val("rd_byte", {24'd0, got}, {24'd0, txd[i]});
                if (i < n - 1) begin
                    tx_data = txd[i + 1];
                    send_bit(I2C_ACK, 1'b0);
                end else begin
                    send_bit(I2C_NACK, 1'b0);
                end
            end
            check_val("oe_after_nack", {31'd0, sda_oe}, 32'd0);
        end else begin
            for (int i = 0; i < n; i++) begin
                send_byte(txd[i], glitch);
                recv_bit(b);
                check_val("data_ack", {31'd0, b}, {31'd0, match ? I2C_ACK : I2C_NACK});
                if (match) exp_q.push_back(txd[i]);
            end
        end
        if (do_stop) begin
            bus_stop();
            exp_busy = 1'b0;
            check_val("busy_after_stop", {31'd0, busy}, 32'd0);
            check_val("state_after_stop", {29'd0, dbg_state_o}, {29'd0, ST_IDLE});
        end
        check_val("addr_hit_cnt", hit_cnt, {31'd0, match});
        check_val("tx_req_cnt", txr_cnt, (match && rwb == RW_READ) ? n : 0);
        check_val("rx_valid_cnt", rxv_cnt, exp_q.size());
        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            got   = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            check_val("rx_data", {24'd0, got}, {24'd0, exp_b});
        end
        if (match && rwb == RW_WRITE && n > 0)
            check_val("rx_data_hold", {24'd0, rx_data}, {24'd0, txd[n - 1]});
        check_val("oe_seen", {31'd0, oe_seen}, {31'd0, match});
        check_val("pulse_overlap", overlap, 0);
        check_val("rw", {31'd0, rw}, {31'd0, last_rw});
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_sda_oe"}, {31'd0, sda_oe}, 32'd0);
        check_val({tag, "_tx_req"}, {31'd0, tx_req}, 32'd0);
        check_val({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
        check_val({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
        check_val({tag, "_addr_hit"}, {31'd0, addr_hit}, 32'd0);
        check_val({tag, "_rw"}, {31'd0, rw}, 32'd0);
        check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_val({tag, "_state"}, {29'd0, dbg_state_o}, {29'd0, ST_IDLE});
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic       b;
        logic [7:0] d;
        logic [6:0] a;
        areset_n = 1'b0;
        scl_m    = 1'b1;
        sda_m    = 1'b1;
        tx_data  = 8'h00;
        exp_busy = 1'b0;
        last_rw  = 1'b0;
        wait_clk(3);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        areset_n = 1'b1;
        wait_clk(Q);

        // T1: write one byte
        txd[0] = 8'h81;
        run_txn(7'h7F, RW_WRITE, 1, 1'b0, 1'b1);

        // T2: read two bytes, ACK then NACK
        txd[0] = 8'hA5; txd[1] = 8'h3C;
        run_txn(7'h7F, RW_READ, 2, 1'b0, 1'b1);

        // T3: address mismatch
        txd[0] = 8'h55;
        run_txn(7'h78, RW_WRITE, 1, 1'b0, 1'b1);

        // T4: write, repeated START, read
        txd[0] = 8'h12;
        run_txn(7'h7F, RW_WRITE, 1, 1'b0, 1'b0);
        txd[0] = 8'($urandom_range(0, 255));
        run_txn(7'h7F, RW_READ, 1, 1'b0, 1'b1);

        // T6: SDA glitches while SCL low during data bytes
        txd[0] = 8'($urandom_range(0, 255)); txd[1] = 8'($urandom_range(0, 255));
        run_txn(7'h7F, RW_WRITE, 2, 1'b1, 1'b1);

        // T5a: reset during bit 4 of a read byte the target is driving low
        hit_cnt = 0;
        bus_start();
        send_byte({7'h7F, RW_READ}, 1'b0);
        tx_data = 8'h00;
        recv_bit(b);
        check_val("abort_addr_ack", {31'd0, b}, {31'd0, I2C_ACK});
        for (int i = 0; i < 3; i++) begin
            recv_bit(b);
            check_val("abort_rd_bit", {31'd0, b}, 32'd0);
        end
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(2);
        @(negedge clk);
        check_val("abort_oe_before", {31'd0, sda_oe}, 32'd1);
        @(posedge clk);
        areset_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        wait_clk(2);
        areset_n = 1'b1;
        exp_busy = 1'b0;
        last_rw  = 1'b0;
        wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
        bus_stop();
        wait_clk(Q);

        // T5b: STOP after bit 3 of a write byte
        rxv_cnt = 0;
        bus_start();
        send_byte({7'h7F, RW_WRITE}, 1'b0);
        recv_bit(b);
        check_val("stop_mid_addr_ack", {31'd0, b}, {31'd0, I2C_ACK});
        d = 8'($urandom_range(0, 255));
        for (int i = 7; i >= 5; i--) send_bit(d[i], 1'b0);
        bus_stop();
        wait_clk(Q);
        check_val("stop_mid_rx_valid_cnt", rxv_cnt, 0);
        check_val("stop_mid_state", {29'd0, dbg_state_o}, {29'd0, ST_IDLE});
        check_val("stop_mid_busy", {31'd0, busy}, 32'd0);
        check_val("stop_mid_oe", {31'd0, sda_oe}, 32'd0);

        // Randomized transfers
        for (int t = 0; t < 8; t++) begin
            a = ($urandom_range(0, 1) == 1) ? SLAVE_ADDR : 7'($urandom_range(0, 126));
            for (int i = 0; i < 4; i++) txd[i] = 8'($urandom_range(0, 255));
            run_txn(a, 1'($urandom_range(0, 1)), $urandom_range(1, 3),
                    1'($urandom_range(0, 1)), 1'b1);
        end

        wait_clk(Q);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
